// File: rtl/inv_key_schedule_if.sv
// Handshake and key bus between the inverse key schedule and its consumer.
// The round controller drives the master side; the schedule implements the slave side.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] last_key;
  logic         key_ack;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, key_ack,
    input  round_key, round_num, key_valid, busy, done
  );

  modport slave (
    input  start, last_key, key_ack,
    output round_key, round_num, key_valid, busy, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 round keys in reverse order (10 down to 0), one per handshake.
// Each earlier key is derived from the current one by inverting a forward expansion step.
module inv_key_schedule #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic                clk,
  input logic                rst,
  inv_key_schedule_if.slave  ks
);

  // AES forward S-box, byte 0x00 occupies the leftmost 8 bits.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, HOLD, CALC} state_t;

  state_t       state;
  logic [127:0] round_key_q;
  logic [3:0]   round_num_q;
  logic         key_valid_q;
  logic         busy_q;
  logic         done_q;

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot;
  logic [7:0]   rcon;
  logic [127:0] prev_key;

  // Undo w[i] = w[i-4] ^ temp: the three later words fall out by XOR, word 0 needs p3's SubWord.
  always_comb begin
    k0 = round_key_q[127:96];
    k1 = round_key_q[95:64];
    k2 = round_key_q[63:32];
    k3 = round_key_q[31:0];
    p3 = k3 ^ k2;
    p2 = k2 ^ k1;
    p1 = k1 ^ k0;
    rot = {p3[23:0], p3[31:24]};
    case (round_num_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    p0 = k0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {rcon, 24'h0};
    prev_key = {p0, p1, p2, p3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      round_key_q <= '0;
      round_num_q <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (ks.start) begin
            round_key_q <= ks.last_key;
            round_num_q <= 4'(NUM_ROUNDS);
            key_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (ks.key_ack) begin
            key_valid_q <= 1'b0;
            if (round_num_q == 4'd0) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          round_key_q <= prev_key;
          round_num_q <= round_num_q - 4'd1;
          key_valid_q <= 1'b1;
          state       <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ks.round_key = round_key_q;
  assign ks.round_num = round_num_q;
  assign ks.key_valid = key_valid_q;
  assign ks.busy      = busy_q;
  assign ks.done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: keys are predicted by running the forward AES-128
// expansion from round 0, with the S-box built from GF(2^8) inversion plus the affine map.
module tb_inv_key_schedule;

  logic tb_clk = 1'b0;
  logic rst;

  inv_key_schedule_if ks_if ();

  inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk (tb_clk),
    .rst (rst),
    .ks  (ks_if)
  );

  always #5 tb_clk = ~tb_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sbox_m   [256];
  logic [127:0] exp_keys [11];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_key"},   ks_if.round_key, '0);
    check({tag, "_num"},   128'(ks_if.round_num), '0);
    check({tag, "_valid"}, 128'(ks_if.key_valid), '0);
    check({tag, "_busy"},  128'(ks_if.busy), '0);
    check({tag, "_done"},  128'(ks_if.done), '0);
  endtask

  // stall_r/abort_r/startack_r pick a round for that disturbance (-1 = none).
  task automatic run_seq(input logic [127:0] key0, input logic [127:0] kat9,
                         input int stall_r, input int abort_r, input int startack_r,
                         input bit hold_ack, input bit b2b);
    logic [127:0] held;
    expand(key0);
    ks_if.last_key = exp_keys[10];
    ks_if.start    = 1'b1;
    tick();
    ks_if.start    = 1'b0;
    ks_if.last_key = ~exp_keys[10];
    for (int r = 10; r >= 0; r--) begin
      check("hold_key",   ks_if.round_key, exp_keys[r]);
      check("hold_num",   128'(ks_if.round_num), 128'(r));
      check("hold_valid", 128'(ks_if.key_valid), 128'(1));
      check("hold_done",  128'(ks_if.done), 128'(0));
      check("hold_busy",  128'(ks_if.busy), 128'(1));
      if (r == 9 && kat9 != '0) check("kat_round9", ks_if.round_key, kat9);
      if (r == stall_r) begin
        held = ks_if.round_key;
        for (int i = 0; i < 20; i++) begin
          ks_if.start    = (i == 10);
          ks_if.last_key = {$urandom, $urandom, $urandom, $urandom};
          tick();
          ks_if.start = 1'b0;
          check("stall_key",   ks_if.round_key, held);
          check("stall_num",   128'(ks_if.round_num), 128'(r));
          check("stall_valid", 128'(ks_if.key_valid), 128'(1));
        end
      end
      if (r == abort_r) begin
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        rst = 1'b0;
        ks_if.key_ack = 1'b0;
        return;
      end
      ks_if.start   = (r == startack_r);
      ks_if.key_ack = 1'b1;
      tick();
      ks_if.start = 1'b0;
      if (!hold_ack) ks_if.key_ack = 1'b0;
      if (r > 0) begin
        check("calc_valid", 128'(ks_if.key_valid), 128'(0));
        check("calc_busy",  128'(ks_if.busy), 128'(1));
        check("calc_done",  128'(ks_if.done), 128'(0));
        tick();
      end else begin
        check("done_pulse", 128'(ks_if.done), 128'(1));
        check("done_valid", 128'(ks_if.key_valid), 128'(0));
        check("done_busy",  128'(ks_if.busy), 128'(0));
        check("done_key",   ks_if.round_key, key0);
        check("done_num",   128'(ks_if.round_num), 128'(0));
        if (!b2b) begin
          tick();
          check("done_once",  128'(ks_if.done), 128'(0));
          check("after_key",  ks_if.round_key, key0);
          check("after_busy", 128'(ks_if.busy), 128'(0));
        end
      end
    end
    ks_if.key_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    ks_if.start    = 1'b0;
    ks_if.key_ack  = 1'b0;
    ks_if.last_key = '0;
    build_sbox();
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;

    ks_if.key_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ack_valid", 128'(ks_if.key_valid), 128'(0));
      check("idle_ack_busy",  128'(ks_if.busy), 128'(0));
    end
    ks_if.key_ack = 1'b0;

    run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hac7766f319fadc2128d12941575c006e,
            -1, -1, -1, 1'b0, 1'b1);
    run_seq('0, '0, -1, -1, -1, 1'b0, 1'b0);
    run_seq({$urandom, $urandom, $urandom, $urandom}, '0, 7, -1, 3, 1'b0, 1'b0);
    run_seq({$urandom, $urandom, $urandom, $urandom}, '0, -1, 4, -1, 1'b0, 1'b0);
    run_seq({$urandom, $urandom, $urandom, $urandom}, '0, -1, -1, -1, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++)
      run_seq({$urandom, $urandom, $urandom, $urandom}, '0, -1, -1, -1, 1'($urandom_range(0, 1)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
